id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_i (all state updates on its rising edge) and rst_i (sampled only at that edge).
REQ-002 clk_i  in  1  rising-edge clock.
REQ-003 rst_i  in  1  synchronous reset, active high.
REQ-004 valid_i  in  1  ID holds a real instruction.
REQ-005 RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  ID source and destination register indices.
REQ-006 RS1data_i, RS2data_i  in  32 each  operand data from the register file read ports (already write-bypassed).
REQ-007 imm_i  in  32  sign-extended immediate.
REQ-008 ctrl_i  in  8  decoded control: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] Branch.
REQ-009 flush_i  in  1  branch or jump redirect; kill the ID instruction.
REQ-010 stall_o  out  1  load-use hazard; hold PC and IF/ID.
REQ-011 valid_o, RS1addr_o, RS2addr_o, RDaddr_o, RS1data_o, RS2data_o, imm_o, ctrl_o  out  same widths as inputs  registered EX-stage copies.
REQ-012 stall_cnt_o  out  16  saturating count of load-use stall cycles.

Function
REQ-013 stall_o SHALL be combinational: valid_i & valid_o & ctrl_o[5] & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i).
REQ-014 Both source fields SHALL be compared regardless of instruction format; spurious stalls are acceptable, missed stalls are not.
REQ-015 Each edge SHALL apply exactly one action, in priority order: reset, flush, bubble, advance.
REQ-016 Flush: flush_i=1 SHALL load a bubble on the next edge, even when stall_o=1.
REQ-017 Bubble: stall_o=1 with flush_i=0 SHALL load a bubble.
REQ-018 A bubble SHALL be all registered outputs zero: valid_o=0, ctrl_o=8'h00, addresses=0, data=0, imm=0.
REQ-019 Advance: with neither flush nor stall, all inputs SHALL register to the outputs with one-cycle latency.
REQ-020 When advancing with valid_i=0, ctrl_o SHALL be forced to 8'h00; the other fields are registered as presented.
REQ-021 A bubble clears valid_o, so stall_o SHALL deassert the cycle after any stall; the maximum stall length is 1 cycle.
REQ-022 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1 and flush_i=0, and hold at 16'hFFFF (no wrap).
REQ-023 RDaddr_o=0 with MemRead set SHALL never stall.

Reset
REQ-024 With rst_i=1 at an edge, every registered output SHALL become 0, which also forces stall_o=0.
REQ-025 Reset SHALL take priority over flush_i and stall_o, including a reset applied in the middle of a stall cycle.
REQ-026 The first instruction after reset release SHALL advance on the following edge.

Structure
REQ-027 A shared package SHALL hold the ctrl bit-position constants, CTRL_W=8, the bubble constant 8'h00, and STALL_CNT_MAX.
REQ-028 Hazard comparison SHALL be a combinational sub-module, hazard_detect; the pipeline register and counter reside in id_ex_stage.

Verification
REQ-029 Advance: valid_i=1, RS1addr_i=3, RS1data_i=32'h1234, ctrl_i=8'h88 -> next cycle valid_o=1, RS1data_o=32'h1234, ctrl_o=8'h88, stall_o=0.
REQ-030 Load-use: EX holds a load (ctrl_o[5]=1, RDaddr_o=5); ID has RS2addr_i=5 -> stall_o=1 the same cycle; next cycle valid_o=0, ctrl_o=0, stall_cnt_o=1, stall_o=0.
REQ-031 x0 load: EX holds a load with RDaddr_o=0; ID has RS1addr_i=0 -> stall_o=0, instruction advances.
REQ-032 Flush during stall: stall_o=1 and flush_i=1 -> bubble loaded, stall_cnt_o unchanged.
REQ-033 Saturation: preload stall_cnt_o to 16'hFFFE, apply 3 stall cycles -> 16'hFFFF, then holds.
REQ-034 Reset mid-stall: rst_i=1 while stall_o=1 -> next cycle all outputs 0, stall_cnt_o=0, stall_o=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its
// load-use hazard detector.
package id_ex_stage_pkg;

  localparam int unsigned CTRL_W      = 8;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned STALL_CNT_W = 16;

  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_MEM_READ   = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_ALU_OP_HI  = 2;
  localparam int unsigned CTRL_ALU_OP_LO  = 1;
  localparam int unsigned CTRL_BRANCH     = 0;

  localparam logic [CTRL_W-1:0]      CTRL_BUBBLE   = 8'h00;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              stall_o
);

  // Both sources are compared whatever the format; x0 never produces a hazard.
  always_comb begin
    stall_o = id_valid_i & ex_valid_i & ex_mem_read_i
            & (ex_rd_i != REG_AW'(0))
            & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and a
// saturating stall-cycle counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [REG_AW-1:0]      RS1addr_i,
  input  logic [REG_AW-1:0]      RS2addr_i,
  input  logic [REG_AW-1:0]      RDaddr_i,
  input  logic [XLEN-1:0]        RS1data_i,
  input  logic [XLEN-1:0]        RS2data_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [CTRL_W-1:0]      ctrl_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   valid_o,
  output logic [REG_AW-1:0]      RS1addr_o,
  output logic [REG_AW-1:0]      RS2addr_o,
  output logic [REG_AW-1:0]      RDaddr_o,
  output logic [XLEN-1:0]        RS1data_o,
  output logic [XLEN-1:0]        RS2data_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [CTRL_W-1:0]      ctrl_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  id_ex_t                 pipe_d, pipe_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic                   stall;

  hazard_detect u_hazard_detect (
    .id_valid_i    (valid_i),
    .id_rs1_i      (RS1addr_i),
    .id_rs2_i      (RS2addr_i),
    .ex_valid_i    (pipe_q.valid),
    .ex_mem_read_i (pipe_q.ctrl[CTRL_MEM_READ]),
    .ex_rd_i       (pipe_q.rd_addr),
    .stall_o       (stall)
  );

  // Flush beats stall; both load a bubble. Only an unflushed stall is counted.
  always_comb begin
    pipe_d      = ID_EX_BUBBLE;
    stall_cnt_d = stall_cnt_q;
    if (!flush_i && !stall) begin
      pipe_d.valid    = valid_i;
      pipe_d.rs1_addr = RS1addr_i;
      pipe_d.rs2_addr = RS2addr_i;
      pipe_d.rd_addr  = RDaddr_i;
      pipe_d.rs1_data = RS1data_i;
      pipe_d.rs2_data = RS2data_i;
      pipe_d.imm      = imm_i;
      pipe_d.ctrl     = valid_i ? ctrl_i : CTRL_BUBBLE;
    end
    if (stall && !flush_i && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q      <= ID_EX_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign valid_o     = pipe_q.valid;
  assign RS1addr_o   = pipe_q.rs1_addr;
  assign RS2addr_o   = pipe_q.rs2_addr;
  assign RDaddr_o    = pipe_q.rd_addr;
  assign RS1data_o   = pipe_q.rs1_data;
  assign RS2data_o   = pipe_q.rs2_data;
  assign imm_o       = pipe_q.imm;
  assign ctrl_o      = pipe_q.ctrl;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared every cycle against a behavioural pipeline model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] d1 = '0, d2 = '0, imm = '0;
  logic [7:0]  ctrl = '0;
  logic        flush = 1'b0;

  logic        stall_o, valid_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] d1_o, d2_o, imm_o;
  logic [7:0]  ctrl_o;
  logic [15:0] cnt_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of the EX-stage contents and the stall counter
  logic        m_valid = 1'b0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [31:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic [7:0]  m_ctrl = '0;
  int unsigned m_cnt = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vin),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd),
    .RS1data_i(d1), .RS2data_i(d2), .imm_i(imm), .ctrl_i(ctrl),
    .flush_i(flush), .stall_o(stall_o), .valid_o(valid_o),
    .RS1addr_o(rs1_o), .RS2addr_o(rs2_o), .RDaddr_o(rd_o),
    .RS1data_o(d1_o), .RS2data_o(d2_o), .imm_o(imm_o), .ctrl_o(ctrl_o),
    .stall_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    return vin && m_valid && m_ctrl[5] && (m_rd != 5'd0) && (m_rd == rs1 || m_rd == rs2);
  endfunction

  // One clock edge applied to the model: reset, flush, bubble, advance
  task automatic model_edge();
    bit s;
    s = exp_stall();
    if (rst || flush || s) begin
      m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
      if (rst) m_cnt = 0;
      else if (!flush && s && m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_valid = vin; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
      m_d1 = d1; m_d2 = d2; m_imm = imm;
      m_ctrl = vin ? ctrl : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] ad, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] im, input logic [7:0] c);
    vin = v; rs1 = a1; rs2 = a2; rd = ad; d1 = x1; d2 = x2; imm = im; ctrl = c;
  endtask

  // Continuous comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall_o", 32'(stall_o), 32'(exp_stall()));
      cmp("valid_o", 32'(valid_o), 32'(m_valid));
      cmp("RS1addr_o", 32'(rs1_o), 32'(m_rs1));
      cmp("RS2addr_o", 32'(rs2_o), 32'(m_rs2));
      cmp("RDaddr_o", 32'(rd_o), 32'(m_rd));
      cmp("RS1data_o", d1_o, m_d1);
      cmp("RS2data_o", d2_o, m_d2);
      cmp("imm_o", imm_o, m_imm);
      cmp("ctrl_o", 32'(ctrl_o), 32'(m_ctrl));
      cmp("stall_cnt_o", 32'(cnt_o), m_cnt);
    end
  end

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_valid", 32'(valid_o), 32'd0);
    cmp("rst_cnt", 32'(cnt_o), 32'd0);
    cmp("rst_stall", 32'(stall_o), 32'd0);

    // Plain advance right after reset release
    rst = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 5'd10, 32'h1234, 32'h5678, 32'h9, 8'h88);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h00);
    @(negedge clk);
    cmp("adv_valid", 32'(valid_o), 32'd1);
    cmp("adv_rs1data", d1_o, 32'h1234);
    cmp("adv_ctrl", 32'(ctrl_o), 32'h88);
    cmp("adv_stall", 32'(stall_o), 32'd0);

    // Load-use on rs2
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 8'hE0);
    tick();
    set_id(1'b1, 5'd1, 5'd5, 5'd6, 32'h33, 32'h44, 32'h0, 8'h80);
    @(negedge clk);
    cmp("lu_stall", 32'(stall_o), 32'd1);
    tick();
    @(negedge clk);
    cmp("lu_valid", 32'(valid_o), 32'd0);
    cmp("lu_ctrl", 32'(ctrl_o), 32'd0);
    cmp("lu_cnt", 32'(cnt_o), 32'd1);
    cmp("lu_stall_drop", 32'(stall_o), 32'd0);
    tick();

    // Load to x0 never stalls
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'hE0);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 5'd8, 32'hAA, 32'hBB, 32'h0, 8'h84);
    @(negedge clk);
    cmp("x0_stall", 32'(stall_o), 32'd0);
    tick();
    @(negedge clk);
    cmp("x0_adv_valid", 32'(valid_o), 32'd1);
    cmp("x0_adv_ctrl", 32'(ctrl_o), 32'h84);

    // Flush during a stall: bubble, counter unchanged
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'hE0);
    tick();
    set_id(1'b1, 5'd7, 5'd3, 5'd9, 32'h0, 32'h0, 32'h0, 8'h80);
    flush = 1'b1;
    @(negedge clk);
    cmp("fl_stall", 32'(stall_o), 32'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    cmp("fl_valid", 32'(valid_o), 32'd0);
    cmp("fl_cnt", 32'(cnt_o), 32'd1);

    // Reset in the middle of a stall
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, 8'hE0);
    tick();
    set_id(1'b1, 5'd9, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 8'h80);
    rst = 1'b1;
    @(negedge clk);
    cmp("rs_stall", 32'(stall_o), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("rs_valid", 32'(valid_o), 32'd0);
    cmp("rs_cnt", 32'(cnt_o), 32'd0);
    cmp("rs_stall_clr", 32'(stall_o), 32'd0);
    tick();
    @(negedge clk);
    cmp("rs_first_adv", 32'(valid_o), 32'd1);

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      set_id(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 8'($urandom));
      vin   = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0;

    // Saturation: preload the counter near the top, then keep stalling
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h00);
    tick();
    force dut.stall_cnt_q = 16'hFFFE;
    m_cnt = 32'hFFFE;
    #1;
    release dut.stall_cnt_q;
    for (int k = 0; k < 3; k++) begin
      set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 8'hE0);
      tick();
      set_id(1'b1, 5'd6, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 8'h80);
      @(negedge clk);
      cmp("sat_stall", 32'(stall_o), 32'd1);
      tick();
      @(negedge clk);
      cmp("sat_cnt", 32'(cnt_o), 32'hFFFF);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
